// File: rtl/fc_mac_accum.sv
// FC1/FC2 neuron pre-activation: a multi-beat LANES-wide dot product seeded with a scaled bias.
// The result is a saturated 23-bit signed sum that feeds the FC quantizer.
module fc_mac_accum #(
    parameter int LANES      = 4,
    parameter int BIAS_SHIFT = 6
) (
    input  logic                 clk,
    input  logic                 srstn,
    input  logic                 start,
    input  logic [7:0]           beats,
    input  logic [7:0]           bias,
    input  logic                 fc_state_in,
    input  logic                 in_valid,
    input  logic [8*LANES-1:0]   act_data,
    input  logic [8*LANES-1:0]   wgt_data,
    output logic                 busy,
    output logic                 out_valid,
    output logic [22:0]          out_data,
    output logic                 fc_state_out
);

    localparam int SUM_W = 16 + $clog2(LANES);
    localparam logic signed [23:0] SAT_MAX = 24'sd4194303;
    localparam logic signed [23:0] SAT_MIN = -24'sd4194304;

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

    state_t                    state_q;
    logic [7:0]                beats_q;
    logic [7:0]                count_q;
    logic                      fc_state_q;
    logic                      busy_q;
    logic                      out_valid_q;
    logic signed [22:0]        out_data_q;
    logic signed [22:0]        acc_q;

    // Pipeline: input register, products, adder tree; each stage carries a valid flag.
    logic [8*LANES-1:0]        act_q;
    logic [8*LANES-1:0]        wgt_q;
    logic                      vld0_q;
    logic signed [15:0]        prod_q [LANES];
    logic                      prodVld_q;
    logic signed [SUM_W-1:0]   sum_q;
    logic                      sumVld_q;

    logic signed [15:0]        prod_d [LANES];
    logic signed [SUM_W-1:0]   sum_d;
    logic signed [23:0]        accWide;
    logic signed [22:0]        acc_d;
    logic signed [22:0]        biasSeed;
    logic                      beatAccept;

    assign beatAccept = (state_q == ACCUM) && in_valid;
    assign biasSeed   = 23'($signed(bias)) <<< BIAS_SHIFT;

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            prod_d[i] = 16'($signed(act_q[8*i +: 8])) * 16'($signed(wgt_q[8*i +: 8]));
        end
    end

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < LANES; i++) begin
            sum_d = sum_d + SUM_W'(prod_q[i]);
        end
    end

    // The 24-bit intermediate cannot overflow, so a simple range clamp is exact.
    always_comb begin
        accWide = 24'(acc_q) + 24'(sum_q);
        if (accWide > SAT_MAX) begin
            acc_d = SAT_MAX[22:0];
        end else if (accWide < SAT_MIN) begin
            acc_d = SAT_MIN[22:0];
        end else begin
            acc_d = accWide[22:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!srstn) begin
            state_q     <= IDLE;
            beats_q     <= '0;
            count_q     <= '0;
            fc_state_q  <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            acc_q       <= '0;
            act_q       <= '0;
            wgt_q       <= '0;
            vld0_q      <= 1'b0;
            prodVld_q   <= 1'b0;
            sum_q       <= '0;
            sumVld_q    <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                prod_q[i] <= '0;
            end
        end else begin
            vld0_q <= beatAccept;
            if (beatAccept) begin
                act_q <= act_data;
                wgt_q <= wgt_data;
            end
            prodVld_q <= vld0_q;
            for (int i = 0; i < LANES; i++) begin
                prod_q[i] <= prod_d[i];
            end
            sumVld_q <= prodVld_q;
            sum_q    <= sum_d;
            if (sumVld_q) begin
                acc_q <= acc_d;
            end
            out_valid_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (start) begin
                        beats_q    <= (beats == 8'd0) ? 8'd1 : beats;
                        fc_state_q <= fc_state_in;
                        count_q    <= '0;
                        acc_q      <= biasSeed;
                        busy_q     <= 1'b1;
                        state_q    <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        count_q <= count_q + 8'd1;
                        if (count_q == beats_q - 8'd1) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Empty pipeline means the final beat has already landed in acc_q.
                    if (!vld0_q && !prodVld_q && !sumVld_q) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= acc_q;
                        busy_q      <= 1'b0;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy         = busy_q;
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign fc_state_out = fc_state_q;

endmodule

// File: tb/tb_fc_mac_accum.sv
// Self-checking bench for fc_mac_accum: directed cases plus random neurons checked
// against a plain integer dot-product-with-clamp model.
module tb_fc_mac_accum;

    localparam int LANES = 4;

    logic               clk = 1'b0;
    logic               srstn;
    logic               start;
    logic [7:0]         beats;
    logic [7:0]         bias;
    logic               fc_state_in;
    logic               in_valid;
    logic [8*LANES-1:0] act_data;
    logic [8*LANES-1:0] wgt_data;
    logic               busy;
    logic               out_valid;
    logic [22:0]        out_data;
    logic               fc_state_out;

    int compared   = 0;
    int mismatched = 0;

    logic [8*LANES-1:0] actMem [256];
    logic [8*LANES-1:0] wgtMem [256];

    fc_mac_accum #(.LANES(LANES), .BIAS_SHIFT(6)) dut (
        .clk          (clk),
        .srstn        (srstn),
        .start        (start),
        .beats        (beats),
        .bias         (bias),
        .fc_state_in  (fc_state_in),
        .in_valid     (in_valid),
        .act_data     (act_data),
        .wgt_data     (wgt_data),
        .busy         (busy),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .fc_state_out (fc_state_out)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input longint obs, input longint expv);
        compared++;
        if (obs !== expv) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int dotBeat(input logic [8*LANES-1:0] a, input logic [8*LANES-1:0] w);
        int s;
        byte sa;
        byte sw;
        s = 0;
        for (int i = 0; i < LANES; i++) begin
            sa = a[8*i +: 8];
            sw = w[8*i +: 8];
            s += int'(sa) * int'(sw);
        end
        return s;
    endfunction

    function automatic int clampAcc(input int v);
        if (v > 4194303) return 4194303;
        if (v < -4194304) return -4194304;
        return v;
    endfunction

    function automatic longint outSigned();
        return longint'($signed(out_data));
    endfunction

    task automatic applyReset(input int cycles);
        srstn = 1'b0;
        repeat (cycles) tick();
        checkOutput("resetBusy", busy, 0);
        checkOutput("resetOutValid", out_valid, 0);
        checkOutput("resetOutData", outSigned(), 0);
        checkOutput("resetFcState", fc_state_out, 0);
        srstn = 1'b1;
    endtask

    // Runs one neuron from actMem/wgtMem; gap < 0 picks random bubbles per beat.
    task automatic applyStimulus(input string name, input int beatsField, input int biasVal,
                                 input bit fcs, input int gap, input bit pokeAccum,
                                 input bit pokeDone);
        int  n;
        int  g;
        int  expAcc;
        int  lat;
        bit  seen;
        n = (beatsField == 0) ? 1 : beatsField;
        start       = 1'b1;
        beats       = 8'(beatsField);
        bias        = 8'(biasVal);
        fc_state_in = fcs;
        in_valid    = 1'b0;
        tick();
        start       = 1'b0;
        fc_state_in = ~fcs;
        bias        = 8'($urandom);
        checkOutput({name, " busyAfterStart"}, busy, 1);
        checkOutput({name, " fcAfterStart"}, fc_state_out, fcs);
        expAcc = biasVal * 64;
        for (int b = 0; b < n; b++) begin
            g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            for (int j = 0; j < g; j++) begin
                in_valid = 1'b0;
                act_data = $urandom;
                wgt_data = $urandom;
                if (pokeAccum && b == 0 && j == 0) begin
                    start       = 1'b1;
                    beats       = 8'd1;
                    bias        = 8'd5;
                    fc_state_in = ~fcs;
                end
                tick();
                start = 1'b0;
            end
            in_valid = 1'b1;
            act_data = actMem[b];
            wgt_data = wgtMem[b];
            tick();
            expAcc = clampAcc(expAcc + dotBeat(actMem[b], wgtMem[b]));
            if (b == 0 || b == n - 1) begin
                checkOutput({name, " busyInAccum"}, busy, 1);
                checkOutput({name, " noEarlyValid"}, out_valid, 0);
            end
        end
        in_valid = 1'b1;
        act_data = $urandom;
        wgt_data = $urandom;
        seen = 1'b0;
        lat  = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (out_valid) begin
                seen = 1'b1;
                lat  = k;
                break;
            end
        end
        in_valid = 1'b0;
        checkOutput({name, " outValidSeen"}, seen, 1);
        if (seen) begin
            checkOutput({name, " latency"}, lat, 4);
            checkOutput({name, " outData"}, outSigned(), expAcc);
            checkOutput({name, " fcStateOut"}, fc_state_out, fcs);
            checkOutput({name, " busyLowInDone"}, busy, 0);
        end
        if (pokeDone) begin
            start       = 1'b1;
            beats       = 8'd1;
            bias        = 8'd0;
            fc_state_in = 1'b0;
        end
        tick();
        checkOutput({name, " pulseOneCycle"}, out_valid, 0);
        checkOutput({name, " outDataHeld"}, outSigned(), expAcc);
        checkOutput({name, " idleAfterDone"}, busy, 0);
    endtask

    task automatic fillConst(input int n, input logic [8*LANES-1:0] a, input logic [8*LANES-1:0] w);
        for (int i = 0; i < n; i++) begin
            actMem[i] = a;
            wgtMem[i] = w;
        end
    endtask

    initial begin
        int  sawValid;
        int  nb;
        srstn       = 1'b0;
        start       = 1'b0;
        beats       = '0;
        bias        = '0;
        fc_state_in = 1'b0;
        in_valid    = 1'b0;
        act_data    = '0;
        wgt_data    = '0;

        applyReset(2);

        // in_valid without start must do nothing
        sawValid = 0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            act_data = $urandom;
            wgt_data = $urandom;
            tick();
            if (out_valid) sawValid++;
        end
        in_valid = 1'b0;
        checkOutput("idleNoValid", sawValid, 0);
        checkOutput("idleBusy", busy, 0);
        checkOutput("idleOutData", outSigned(), 0);

        fillConst(1, {8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5});
        applyStimulus("single", 1, 0, 1'b0, 0, 1'b0, 1'b0);

        fillConst(3, 32'h01010101, 32'hFEFEFEFE);
        applyStimulus("biasGaps", 3, 1, 1'b1, 2, 1'b0, 1'b0);

        fillConst(255, 32'h7F7F7F7F, 32'h7F7F7F7F);
        applyStimulus("satPos", 255, 0, 1'b0, 0, 1'b0, 1'b0);

        fillConst(255, 32'h7F7F7F7F, 32'h80808080);
        applyStimulus("satNeg", 255, 0, 1'b1, 0, 1'b0, 1'b0);

        // Saturate high, then pull back into range with negative beats.
        fillConst(70, 32'h7F7F7F7F, 32'h7F7F7F7F);
        for (int i = 70; i < 80; i++) begin
            actMem[i] = 32'h7F7F7F7F;
            wgtMem[i] = 32'h80808080;
        end
        applyStimulus("desat", 80, 0, 1'b0, 0, 1'b0, 1'b0);

        fillConst(1, {8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5});
        applyStimulus("busyStart", 1, 0, 1'b0, 1, 1'b1, 1'b1);
        applyStimulus("afterDone", 1, 0, 1'b0, 0, 1'b0, 1'b0);

        fillConst(1, 32'h02020202, 32'h03030303);
        applyStimulus("beatsZero", 0, -3, 1'b1, 0, 1'b0, 1'b0);

        // Abort a 4-beat neuron after 2 beats.
        fillConst(4, 32'h11111111, 32'h22222222);
        start       = 1'b1;
        beats       = 8'd4;
        bias        = 8'd7;
        fc_state_in = 1'b1;
        tick();
        start = 1'b0;
        for (int b = 0; b < 2; b++) begin
            in_valid = 1'b1;
            act_data = actMem[b];
            wgt_data = wgtMem[b];
            tick();
        end
        in_valid = 1'b0;
        applyReset(1);
        sawValid = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) sawValid++;
        end
        checkOutput("abortNoValid", sawValid, 0);
        checkOutput("abortBusy", busy, 0);
        fillConst(1, {8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5});
        applyStimulus("fresh", 1, 0, 1'b0, 0, 1'b0, 1'b0);

        for (int r = 0; r < 20; r++) begin
            nb = int'($urandom_range(0, 12));
            for (int i = 0; i < 12; i++) begin
                actMem[i] = $urandom;
                wgtMem[i] = $urandom;
            end
            applyStimulus($sformatf("rand%0d", r), nb, int'($urandom_range(0, 255)) - 128,
                          1'($urandom), -1, 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
